// File: rtl/sum_stage_pkg.sv
// Shared types and widths for the sum stage: control words, pipe words and
// the per-row partial-sum fitting rule (saturate or wrap).
package sum_stage_pkg;

   localparam int PEROW   = 8;
   localparam int PSUMDWD = 16;
   localparam int ASUMDWD = 12;
   localparam int CNTW    = 4;
   localparam int PPCTLW  = 4;

   // acc_len holds (beats - 1) so a group of one beat is encoded as zero
   typedef struct packed {
      logic [CNTW-1:0] acc_len;
      logic            psum_sel;
      logic            sat_en;
   } ssctl_t;

   typedef logic [PPCTLW-1:0] ppctl_t;

   typedef struct packed {
      ssctl_t ssctl;
      ppctl_t ssppctl;
   } mspipe_t;

   typedef struct packed {
      logic [PSUMDWD-1:0] psum_ms;
      logic [ASUMDWD-1:0] sum_ms;
   } msout_t;

   localparam int MSOUTW  = $bits(msout_t);
   localparam int MSPIPEW = $bits(mspipe_t);

   typedef enum logic {ACC_FIRST, ACC_REST} ss_state_t;

   // Bring a PSUMDWD+1 bit sum back to PSUMDWD bits: clamp when the two top
   // bits disagree and saturation is on, otherwise just drop the MSB.
   function automatic logic [PSUMDWD-1:0] fit_psum(input logic [PSUMDWD:0] s,
                                                    input logic sat_en);
      logic [PSUMDWD-1:0] r;
      r = s[PSUMDWD-1:0];
      if (sat_en && (s[PSUMDWD] != s[PSUMDWD-1]))
         r = s[PSUMDWD] ? {1'b1, {(PSUMDWD-1){1'b0}}} : {1'b0, {(PSUMDWD-1){1'b1}}};
      return r;
   endfunction

endpackage

// File: rtl/sum_stage_acc.sv
// One PE row of the sum stage: picks the accumulation base, sign-extends the
// MS sum, adds one bit wide and fits the result back to PSUMDWD bits.
module ss_acc_unit
   import sum_stage_pkg::*;
(
   input  logic               first,
   input  logic               psum_sel,
   input  logic               sat_en,
   input  logic [PSUMDWD-1:0] acc,
   input  logic [PSUMDWD-1:0] psum_ms,
   input  logic [ASUMDWD-1:0] sum_ms,
   output logic [PSUMDWD-1:0] acc_nxt
);

   logic [PSUMDWD-1:0] base;
   logic [PSUMDWD:0]   sum_wide;

   // First beat starts from Psum_MS or zero; later beats build on the row accumulator
   always_comb begin
      base     = first ? (psum_sel ? psum_ms : '0) : acc;
      sum_wide = {base[PSUMDWD-1], base}
               + {{(PSUMDWD+1-ASUMDWD){sum_ms[ASUMDWD-1]}}, sum_ms};
      acc_nxt  = fit_psum(sum_wide, sat_en);
   end

endmodule

// File: rtl/sum_stage.sv
// Sum stage: accumulates the MS adder-tree sums of every PE row over a group
// of beats and hands one partial sum per group to PP over rdy/ack. Holds one
// finished group in the output register while the next group accumulates.
module sum_stage
   import sum_stage_pkg::*;
(
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            MS_rdy,
   output logic                            MS_ack,
   input  logic [PEROW-1:0][MSOUTW-1:0]    i_data,
   input  logic [MSPIPEW-1:0]              i_MSpipe,
   output logic                            SS_rdy,
   input  logic                            SS_ack,
   output logic [PEROW-1:0][PSUMDWD-1:0]   o_data,
   output logic [PPCTLW-1:0]               o_ppctl
);

   ss_state_t                   state, state_nxt;
   mspipe_t                     pipe;
   ssctl_t                      ctl_q, ctl_cur;
   logic [CNTW-1:0]             cnt;
   logic [PEROW-1:0][PSUMDWD-1:0] acc_q, acc_nxt;
   logic                        first, is_last, beat;

   // Decode the beat: which control applies, whether it closes the group, and
   // whether it must wait for the previous result to drain
   always_comb begin
      pipe      = i_MSpipe;
      first     = (state == ACC_FIRST);
      ctl_cur   = first ? pipe.ssctl : ctl_q;
      is_last   = first ? (pipe.ssctl.acc_len == '0) : (cnt == ctl_q.acc_len);
      MS_ack    = MS_rdy && !(is_last && SS_rdy && !SS_ack);
      beat      = MS_rdy && MS_ack;
      state_nxt = state;
      if (beat)
         state_nxt = is_last ? ACC_FIRST : ACC_REST;
   end

   for (genvar r = 0; r < PEROW; r++) begin : g_row
      msout_t din;
      assign din = i_data[r];
      ss_acc_unit u_acc (
         .first   (first),
         .psum_sel(ctl_cur.psum_sel),
         .sat_en  (ctl_cur.sat_en),
         .acc     (acc_q[r]),
         .psum_ms (din.psum_ms),
         .sum_ms  (din.sum_ms),
         .acc_nxt (acc_nxt[r])
      );
   end

   // Group FSM state register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= ACC_FIRST;
      else       state <= state_nxt;
   end

   // Accumulators, beat counter and the control latched on a group's first beat
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_q <= '0;
         cnt   <= '0;
         ctl_q <= '0;
      end else if (beat) begin
         acc_q <= acc_nxt;
         if (first) begin
            ctl_q <= pipe.ssctl;
            cnt   <= CNTW'(1);
         end else begin
            cnt   <= cnt + CNTW'(1);
         end
      end
   end

   // Result register: loads on a group's last beat, otherwise holds and only
   // drops valid once PP has taken it
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         SS_rdy  <= 1'b0;
         o_data  <= '0;
         o_ppctl <= '0;
      end else if (beat && is_last) begin
         SS_rdy  <= 1'b1;
         o_data  <= acc_nxt;
         o_ppctl <= pipe.ssppctl;
      end else if (SS_ack) begin
         SS_rdy  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sum_stage.sv
// Directed bench for sum_stage: reset, single/multi-beat groups, saturation
// and wrap, output backpressure and reset in the middle of a group.
module tb_sum_stage;
   import sum_stage_pkg::*;

   logic clk = 1'b0;
   logic rst, ms_rdy, ms_ack, ss_rdy, ss_ack;
   logic [PEROW-1:0][MSOUTW-1:0]  data;
   logic [MSPIPEW-1:0]            mspipe;
   logic [PEROW-1:0][PSUMDWD-1:0] odata;
   logic [PPCTLW-1:0]             oppctl;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sum_stage dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .MS_rdy  (ms_rdy),
      .MS_ack  (ms_ack),
      .i_data  (data),
      .i_MSpipe(mspipe),
      .SS_rdy  (ss_rdy),
      .SS_ack  (ss_ack),
      .o_data  (odata),
      .o_ppctl (oppctl)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one MS beat; row r gets Sum_MS = sum + r*step
   task automatic drive(input int acc_len, input bit psum_sel, input bit sat_en,
                        input int ppctl, input int psum, input int sum, input int step);
      mspipe_t p;
      msout_t  d;
      p.ssctl.acc_len  = CNTW'(acc_len);
      p.ssctl.psum_sel = psum_sel;
      p.ssctl.sat_en   = sat_en;
      p.ssppctl        = PPCTLW'(ppctl);
      mspipe = p;
      for (int r = 0; r < PEROW; r++) begin
         d.psum_ms = PSUMDWD'(psum);
         d.sum_ms  = ASUMDWD'(sum + r*step);
         data[r]   = d;
      end
      ms_rdy = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; ss_ack = 1'b0;
      drive(0, 1, 0, 3, 100, -30, 0);
      tick(); tick();
      checks++;
      if (ss_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b want 0", ss_rdy); end
      checks++;
      if (odata !== '0 || oppctl !== '0) begin
         failures++; $display("FAIL reset_data: got %h/%h want 0/0", odata, oppctl);
      end
      rst = 1'b0; ms_rdy = 1'b0;
      tick();
      checks++;
      if (ss_rdy !== 1'b0) begin failures++; $display("FAIL reset_leak: got %b want 0", ss_rdy); end
   endtask

   task automatic test_single();
      ss_ack = 1'b1;
      drive(0, 1, 1, 5, 100, -30, 1);
      #1;
      checks++;
      if (ms_ack !== 1'b1) begin failures++; $display("FAIL single_ack: got %b want 1", ms_ack); end
      tick(); ms_rdy = 1'b0;
      checks++;
      if (ss_rdy !== 1'b1 || oppctl !== 4'd5) begin
         failures++; $display("FAIL single_rdy: got rdy=%b ppctl=%0d want 1/5", ss_rdy, oppctl);
      end
      for (int r = 0; r < PEROW; r++) begin
         checks++;
         if (odata[r] !== PSUMDWD'(70 + r)) begin
            failures++; $display("FAIL single_data row%0d: got %0d want %0d", r, $signed(odata[r]), 70 + r);
         end
      end
      tick();
      checks++;
      if (ss_rdy !== 1'b0 || odata[0] !== 16'd70) begin
         failures++; $display("FAIL single_drain: got rdy=%b d0=%0d want 0/70", ss_rdy, $signed(odata[0]));
      end
   endtask

   // acc_len/psum_sel on later beats must be ignored
   task automatic test_multi_beat();
      ss_ack = 1'b1;
      for (int b = 0; b < 4; b++) begin
         drive(b == 0 ? 3 : 0, b != 0, 0, b + 1, 1000, 5 + b, 1);
         #1;
         checks++;
         if (ms_ack !== 1'b1) begin failures++; $display("FAIL multi_ack beat%0d: got %b want 1", b, ms_ack); end
         tick();
         if (b < 3) begin
            checks++;
            if (ss_rdy !== 1'b0) begin failures++; $display("FAIL multi_early beat%0d: got %b want 0", b, ss_rdy); end
         end
      end
      ms_rdy = 1'b0;
      checks++;
      if (ss_rdy !== 1'b1 || oppctl !== 4'd4) begin
         failures++; $display("FAIL multi_rdy: got rdy=%b ppctl=%0d want 1/4", ss_rdy, oppctl);
      end
      for (int r = 0; r < PEROW; r++) begin
         checks++;
         if (odata[r] !== PSUMDWD'(26 + 4*r)) begin
            failures++; $display("FAIL multi_data row%0d: got %0d want %0d", r, $signed(odata[r]), 26 + 4*r);
         end
      end
      tick();
   endtask

   task automatic test_saturate();
      int tsat[4]  = '{1, 0, 1, 0};
      int tpsum[4] = '{32760, 32760, -32760, -32760};
      int tsum[4]  = '{20, 20, -20, -20};
      int texp[4]  = '{32767, -32756, -32768, 32756};
      ss_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, tsat[i] != 0, 0, tpsum[i], tsum[i], 0);
         tick(); ms_rdy = 1'b0;
         checks++;
         if (odata[0] !== PSUMDWD'(texp[i]) || odata[PEROW-1] !== PSUMDWD'(texp[i])) begin
            failures++; $display("FAIL sat_case%0d: got %0d want %0d", i, $signed(odata[0]), texp[i]);
         end
         tick();
      end
      // clamp applies per beat, using the sat_en latched on the first beat
      drive(1, 1, 1, 0, 32760, 20, 0);
      tick();
      drive(0, 0, 0, 0, 0, -10, 0);
      tick(); ms_rdy = 1'b0;
      checks++;
      if (ss_rdy !== 1'b1 || odata[3] !== 16'd32757) begin
         failures++; $display("FAIL sat_per_beat: got rdy=%b d=%0d want 1/32757", ss_rdy, $signed(odata[3]));
      end
      tick();
   endtask

   task automatic test_backpressure();
      ss_ack = 1'b0;
      drive(1, 0, 0, 7, 0, 1, 0);
      tick();
      drive(0, 0, 0, 7, 0, 2, 0);
      #1;
      checks++;
      if (ms_ack !== 1'b1) begin failures++; $display("FAIL bp_first_last_ack: got %b want 1", ms_ack); end
      tick();
      checks++;
      if (ss_rdy !== 1'b1 || odata[0] !== 16'd3 || oppctl !== 4'd7) begin
         failures++; $display("FAIL bp_first_result: got rdy=%b d=%0d ppctl=%0d want 1/3/7", ss_rdy, $signed(odata[0]), oppctl);
      end
      drive(1, 0, 0, 8, 0, 10, 0);
      #1;
      checks++;
      if (ms_ack !== 1'b1) begin failures++; $display("FAIL bp_nonlast_ack: got %b want 1", ms_ack); end
      tick();
      drive(0, 0, 0, 9, 0, 20, 0);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (ms_ack !== 1'b0) begin failures++; $display("FAIL bp_stall_ack cyc%0d: got %b want 0", k, ms_ack); end
         tick();
         checks++;
         if (ss_rdy !== 1'b1 || oppctl !== 4'd7) begin
            failures++; $display("FAIL bp_hold_ctl cyc%0d: got rdy=%b ppctl=%0d want 1/7", k, ss_rdy, oppctl);
         end
         for (int r = 0; r < PEROW; r++) begin
            checks++;
            if (odata[r] !== 16'd3) begin
               failures++; $display("FAIL bp_hold_data cyc%0d row%0d: got %0d want 3", k, r, $signed(odata[r]));
            end
         end
      end
      ss_ack = 1'b1;
      #1;
      checks++;
      if (ms_ack !== 1'b1) begin failures++; $display("FAIL bp_release_ack: got %b want 1", ms_ack); end
      tick(); ms_rdy = 1'b0; ss_ack = 1'b0;
      checks++;
      if (ss_rdy !== 1'b1 || odata[5] !== 16'd30 || oppctl !== 4'd9) begin
         failures++; $display("FAIL bp_second_result: got rdy=%b d=%0d ppctl=%0d want 1/30/9", ss_rdy, $signed(odata[5]), oppctl);
      end
      ss_ack = 1'b1;
      tick();
      checks++;
      if (ss_rdy !== 1'b0 || odata[5] !== 16'd30) begin
         failures++; $display("FAIL bp_drain: got rdy=%b d=%0d want 0/30", ss_rdy, $signed(odata[5]));
      end
   endtask

   task automatic test_reset_mid_group();
      ss_ack = 1'b0;
      drive(0, 0, 0, 2, 0, 50, 0);
      tick();
      drive(3, 0, 0, 0, 0, 100, 0);
      tick();
      drive(0, 0, 0, 0, 0, 100, 0);
      tick(); ms_rdy = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (ss_rdy !== 1'b0 || odata !== '0 || oppctl !== '0) begin
         failures++; $display("FAIL midrst_clear: got rdy=%b d0=%0d ppctl=%0d want 0/0/0", ss_rdy, $signed(odata[0]), oppctl);
      end
      drive(0, 0, 0, 1, 0, 9, 0);
      #1;
      checks++;
      if (ms_ack !== 1'b1) begin failures++; $display("FAIL midrst_ack: got %b want 1", ms_ack); end
      tick(); ms_rdy = 1'b0;
      checks++;
      if (ss_rdy !== 1'b1 || odata[2] !== 16'd9 || oppctl !== 4'd1) begin
         failures++; $display("FAIL midrst_next: got rdy=%b d=%0d ppctl=%0d want 1/9/1", ss_rdy, $signed(odata[2]), oppctl);
      end
   endtask

   initial begin
      ms_rdy = 1'b0; ss_ack = 1'b0; rst = 1'b1; data = '0; mspipe = '0;
      test_reset();
      test_single();
      test_multi_beat();
      test_saturate();
      test_backpressure();
      test_reset_mid_group();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
